thumb_instr_encoder: RTL and testbench

Encoder counterpart to the core's instruction decoder. It accepts symbolic instructions (op enum plus register, immediate and condition fields) over a valid/ready handshake. Each legal instruction is packed into the 16-bit Thumb word the decoder expects, and emitted through a one-stage registered valid/ready output together with its sequential word address. Its job is to load instruction memory from a test or boot sequencer.

---
 rtl/thumb_instr_encoder.sv | 237 +++++++++++++++++++++++
 tb/tb_thumb_instr_encoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/thumb_instr_encoder.sv
// -----------------------------------------------------------------------------
// thumb_instr_encoder
//
// Packs symbolic instructions (op enum + register/immediate/condition fields)
// into 16-bit Thumb words for loading instruction memory from a sequencer.
// Legal words leave through a one-stage registered valid/ready output along
// with their sequential word address. Illegal instructions are consumed,
// dropped, flagged by a one-cycle err pulse and counted in err_count.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   clear      synchronous restart (address, error count, output stage)
//   in_valid   symbolic instruction present
//   in_ready   encoder accepts this cycle (the only combinational output)
//   in_op      op enum (0..19 legal, 20..31 illegal)
//   in_rd      destination / Rt / Rdn
//   in_rn      first source / base
//   in_rm      second source
//   in_imm     immediate (two's complement for BCOND and B)
//   in_cond    branch condition for BCOND
//   out_valid  encoded word valid
//   out_ready  consumer accepts word
//   out_instr  encoded 16-bit instruction
//   out_addr   word address of out_instr
//   err        one-cycle pulse: an illegal instruction was dropped
//   err_count  saturating count of dropped instructions
//   full       DEPTH words have been emitted
// -----------------------------------------------------------------------------
module thumb_instr_encoder #(
    parameter int DEPTH = 256,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_op,
    input  logic [2:0]    in_rd,
    input  logic [2:0]    in_rn,
    input  logic [2:0]    in_rm,
    input  logic [10:0]   in_imm,
    input  logic [3:0]    in_cond,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_instr,
    output logic [AW-1:0] out_addr,
    output logic          err,
    output logic [7:0]    err_count,
    output logic          full
);

    // Op enum values.
    localparam logic [4:0] OP_MOVS   = 5'd0;
    localparam logic [4:0] OP_MOV    = 5'd1;
    localparam logic [4:0] OP_ADDS_I = 5'd2;
    localparam logic [4:0] OP_ADDS_R = 5'd3;
    localparam logic [4:0] OP_ADD_SP = 5'd4;
    localparam logic [4:0] OP_SUBS_I = 5'd5;
    localparam logic [4:0] OP_SUBS_R = 5'd6;
    localparam logic [4:0] OP_SUB_SP = 5'd7;
    localparam logic [4:0] OP_CMP    = 5'd8;
    localparam logic [4:0] OP_ANDS   = 5'd9;
    localparam logic [4:0] OP_EORS   = 5'd10;
    localparam logic [4:0] OP_ORRS   = 5'd11;
    localparam logic [4:0] OP_MVNS   = 5'd12;
    localparam logic [4:0] OP_LSLS   = 5'd13;
    localparam logic [4:0] OP_LSRS   = 5'd14;
    localparam logic [4:0] OP_STR    = 5'd15;
    localparam logic [4:0] OP_LDR    = 5'd16;
    localparam logic [4:0] OP_BCOND  = 5'd17;
    localparam logic [4:0] OP_B      = 5'd18;
    localparam logic [4:0] OP_NOOP   = 5'd19;

    // The counter is one bit wider than out_addr so that it can hold DEPTH
    // itself even when DEPTH == 2**AW; it never wraps.
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    // Returns {legal, word}. Fields an op does not use are ignored.
    function automatic logic [16:0] encode_f(
        input logic [4:0]  op,
        input logic [2:0]  rd,
        input logic [2:0]  rn,
        input logic [2:0]  rm,
        input logic [10:0] imm,
        input logic [3:0]  cond
    );
        logic        legal;
        logic [15:0] word;
        legal = 1'b1;
        word  = 16'h0000;
        case (op)
            OP_MOVS: begin
                word  = {5'b00100, rd, imm[7:0]};
                legal = (imm[10:8] == 3'b000);
            end
            OP_MOV:    word = {8'b01000110, 2'b00, rm, rd};
            OP_ADDS_I: begin
                word  = {7'b0001110, imm[2:0], rn, rd};
                legal = (imm[10:3] == 8'h00);
            end
            OP_SUBS_I: begin
                word  = {7'b0001111, imm[2:0], rn, rd};
                legal = (imm[10:3] == 8'h00);
            end
            OP_ADDS_R: word = {7'b0001100, rm, rn, rd};
            OP_SUBS_R: word = {7'b0001101, rm, rn, rd};
            OP_ADD_SP: begin
                word  = {9'b101100000, imm[6:0]};
                legal = (imm[10:7] == 4'h0);
            end
            OP_SUB_SP: begin
                word  = {9'b101100001, imm[6:0]};
                legal = (imm[10:7] == 4'h0);
            end
            OP_CMP:    word = {10'b0100001010, rm, rn};
            OP_ANDS:   word = {10'b0100000000, rm, rd};
            OP_EORS:   word = {10'b0100000001, rm, rd};
            OP_LSLS:   word = {10'b0100000010, rm, rd};
            OP_LSRS:   word = {10'b0100000011, rm, rd};
            OP_ORRS:   word = {10'b0100001100, rm, rd};
            OP_MVNS:   word = {10'b0100001111, rm, rd};
            OP_STR: begin
                word  = {5'b01100, imm[4:0], rn, rd};
                legal = (imm[10:5] == 6'h00);
            end
            OP_LDR: begin
                word  = {5'b01101, imm[4:0], rn, rd};
                legal = (imm[10:5] == 6'h00);
            end
            OP_BCOND: begin
                // The 8-bit offset field must sign-extend back to the full
                // 11-bit immediate, and cond 1111 is the SVC slot, not a branch.
                word  = {4'b1101, cond, imm[7:0]};
                legal = (imm[10:8] == {3{imm[7]}}) && (cond != 4'b1111);
            end
            OP_B:      word = {5'b11100, imm};
            OP_NOOP:   word = 16'hBF00;
            default: begin
                word  = 16'h0000;
                legal = 1'b0;
            end
        endcase
        return {legal, word};
    endfunction

    // State registers.
    logic          out_valid_q, out_valid_d;
    logic [15:0]   out_instr_q, out_instr_d;
    logic [AW-1:0] out_addr_q,  out_addr_d;
    logic [AW:0]   cnt_q,       cnt_d;
    logic          full_q,      full_d;
    logic          err_q,       err_d;
    logic [7:0]    err_count_q, err_count_d;

    logic [16:0]   enc_s;
    logic          legal_s;
    logic          xfer_s;
    logic [AW:0]   cnt_inc_s;

    // Accept when not full, the output slot is free or draining, and no clear.
    assign in_ready  = !full_q && (!out_valid_q || out_ready) && !clear;
    assign xfer_s    = in_valid && in_ready;
    assign enc_s     = encode_f(in_op, in_rd, in_rn, in_rm, in_imm, in_cond);
    assign legal_s   = enc_s[16];
    assign cnt_inc_s = cnt_q + {{AW{1'b0}}, 1'b1};

    // Next-state logic: clear first, then legal load, illegal drop, or drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        cnt_d       = cnt_q;
        full_d      = full_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        if (clear) begin
            out_valid_d = 1'b0;
            cnt_d       = {(AW+1){1'b0}};
            full_d      = 1'b0;
            err_count_d = 8'h00;
        end else if (xfer_s && legal_s) begin
            // A new word may replace the one draining this same cycle.
            out_valid_d = 1'b1;
            out_instr_d = enc_s[15:0];
            out_addr_d  = cnt_q[AW-1:0];
            cnt_d       = cnt_inc_s;
            full_d      = (cnt_inc_s == DEPTH_C);
        end else begin
            if (out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
            if (xfer_s) begin
                err_d = 1'b1;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end else begin
                    err_count_d = err_count_q;
                end
            end else begin
                err_d = 1'b0;
            end
        end
    end

    // State update with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 16'h0000;
            out_addr_q  <= {AW{1'b0}};
            cnt_q       <= {(AW+1){1'b0}};
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign err       = err_q;
    assign err_count = err_count_q;
    assign full      = full_q;

endmodule

// File: tb/tb_thumb_instr_encoder.sv
// -----------------------------------------------------------------------------
// Testbench for thumb_instr_encoder (DEPTH=4 so the full/clear path is hit
// often). A stimulus process drives one item per cycle, predicts handshake,
// err and full from a behavioural model and pushes expected words into a
// scoreboard queue; a separate monitor compares every presented word.
// -----------------------------------------------------------------------------
module tb_thumb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_op;
    logic [2:0]    in_rd, in_rn, in_rm;
    logic [10:0]   in_imm;
    logic [3:0]    in_cond;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          err;
    logic [7:0]    err_count;
    logic          full;

    thumb_instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
        .in_imm(in_imm), .in_cond(in_cond),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .err_count(err_count), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  op;
        logic [2:0]  rd, rn, rm;
        logic [10:0] imm;
        logic [3:0]  cond;
        logic        ordy;
        logic        clr;
        logic        use_exp;
        logic        exp_legal;
        logic [15:0] exp_word;
    } item_t;

    typedef struct {
        logic [15:0]   w;
        logic [AW-1:0] a;
    } sb_t;

    sb_t sbq[$];
    int  checks   = 0;
    int  failures = 0;

    // Behavioural model state
    int   m_cnt;
    logic m_full, m_ov, m_err;
    int   m_errcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: opcode bases plus field weights, immediates as numbers.
    task automatic ref_encode(input item_t it, output logic legal, output logic [15:0] word);
        int iv, s, w;
        iv = int'(it.imm);
        legal = 1'b1;
        w = 0;
        case (int'(it.op))
            0:  begin w = 'h2000 + it.rd * 256 + (iv % 256); legal = (iv < 256); end
            1:  w = 'h4600 + it.rm * 8 + it.rd;
            2:  begin w = 'h1C00 + (iv % 8) * 64 + it.rn * 8 + it.rd; legal = (iv < 8); end
            3:  w = 'h1800 + it.rm * 64 + it.rn * 8 + it.rd;
            4:  begin w = 'hB000 + (iv % 128); legal = (iv < 128); end
            5:  begin w = 'h1E00 + (iv % 8) * 64 + it.rn * 8 + it.rd; legal = (iv < 8); end
            6:  w = 'h1A00 + it.rm * 64 + it.rn * 8 + it.rd;
            7:  begin w = 'hB080 + (iv % 128); legal = (iv < 128); end
            8:  w = 'h4280 + it.rm * 8 + it.rn;
            9:  w = 'h4000 + it.rm * 8 + it.rd;
            10: w = 'h4040 + it.rm * 8 + it.rd;
            11: w = 'h4300 + it.rm * 8 + it.rd;
            12: w = 'h43C0 + it.rm * 8 + it.rd;
            13: w = 'h4080 + it.rm * 8 + it.rd;
            14: w = 'h40C0 + it.rm * 8 + it.rd;
            15: begin w = 'h6000 + (iv % 32) * 64 + it.rn * 8 + it.rd; legal = (iv < 32); end
            16: begin w = 'h6800 + (iv % 32) * 64 + it.rn * 8 + it.rd; legal = (iv < 32); end
            17: begin
                s = (iv >= 1024) ? iv - 2048 : iv;
                legal = (s >= -128) && (s <= 127) && (it.cond != 4'hF);
                w = 'hD000 + it.cond * 256 + ((s + 256) % 256);
            end
            18: w = 'hE000 + iv;
            19: w = 'hBF00;
            default: begin w = 0; legal = 1'b0; end
        endcase
        word = w[15:0];
    endtask

    function automatic item_t mk(input logic v, input int op, input int rd, input int rn,
                                 input int rm, input int imm, input int cond, input logic ordy,
                                 input logic clr, input logic use_exp, input logic el,
                                 input int ew);
        item_t it;
        it.valid = v;  it.op = 5'(op);  it.rd = 3'(rd);  it.rn = 3'(rn);  it.rm = 3'(rm);
        it.imm = 11'(imm);  it.cond = 4'(cond);  it.ordy = ordy;  it.clr = clr;
        it.use_exp = use_exp;  it.exp_legal = el;  it.exp_word = 16'(ew);
        return it;
    endfunction

    function automatic item_t rand_item();
        item_t it;
        it.valid = ($urandom_range(0, 3) != 0);
        it.op    = 5'($urandom_range(0, 23));
        it.rd    = 3'($urandom_range(0, 7));
        it.rn    = 3'($urandom_range(0, 7));
        it.rm    = 3'($urandom_range(0, 7));
        it.imm   = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, 7)) : 11'($urandom_range(0, 2047));
        it.cond  = 4'($urandom_range(0, 15));
        it.ordy  = ($urandom_range(0, 3) != 0);
        it.clr   = m_full ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
        it.use_exp = 1'b0;  it.exp_legal = 1'b0;  it.exp_word = 16'h0000;
        return it;
    endfunction

    task automatic model_reset();
        m_cnt = 0;  m_full = 1'b0;  m_ov = 1'b0;  m_err = 1'b0;  m_errcnt = 0;
        sbq.delete();
    endtask

    // One cycle: drive at negedge, check state at +1, update model after monitor.
    task automatic step(input item_t it);
        logic rdy, legal, drain;
        logic [15:0] w;
        sb_t e;
        @(negedge clk);
        in_valid = it.valid;  in_op = it.op;  in_rd = it.rd;  in_rn = it.rn;  in_rm = it.rm;
        in_imm = it.imm;  in_cond = it.cond;  out_ready = it.ordy;  clear = it.clr;
        #1;
        rdy = !m_full && (!m_ov || it.ordy) && !it.clr;
        check("in_ready",  32'(in_ready),  32'(rdy));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("err",       32'(err),       32'(m_err));
        check("err_count", 32'(err_count), 32'(m_errcnt));
        check("full",      32'(full),      32'(m_full));
        #2;
        if (it.use_exp) begin
            legal = it.exp_legal;  w = it.exp_word;
        end else begin
            ref_encode(it, legal, w);
        end
        drain = m_ov && it.ordy;
        m_err = 1'b0;
        if (it.clr) begin
            m_cnt = 0;  m_full = 1'b0;  m_ov = 1'b0;  m_errcnt = 0;
            sbq.delete();
        end else if (it.valid && rdy && legal) begin
            e.w = w;  e.a = AW'(m_cnt);
            sbq.push_back(e);
            m_ov = 1'b1;
            m_cnt++;
            if (m_cnt == DEPTH) m_full = 1'b1;
        end else begin
            if (drain) m_ov = 1'b0;
            if (it.valid && rdy) begin
                m_err = 1'b1;
                if (m_errcnt < 255) m_errcnt++;
            end
        end
    endtask

    // Monitor: every presented word must match the scoreboard front.
    always @(negedge clk) begin
        #2;
        if (reset && out_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_word", 32'(out_instr), 32'hFFFF_FFFF);
            end else begin
                check("out_instr", 32'(out_instr), 32'(sbq[0].w));
                check("out_addr",  32'(out_addr),  32'(sbq[0].a));
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    item_t dir[$];

    initial begin
        reset = 1'b0;  clear = 1'b0;  in_valid = 1'b0;  out_ready = 1'b0;
        in_op = 5'd0;  in_rd = 3'd0;  in_rn = 3'd0;  in_rm = 3'd0;
        in_imm = 11'd0;  in_cond = 4'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", 32'(out_instr), 32'd0);
        check("rst_out_addr",  32'(out_addr),  32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_full",      32'(full),      32'd0);
        reset = 1'b1;
        model_reset();

        // Directed sequence with hand-derived encodings.
        dir.push_back(mk(1, 0, 3, 0, 0, 'h5A, 0, 1, 0, 1, 1, 'h235A));   // MOVS addr 0
        dir.push_back(mk(1, 2, 1, 2, 0, 5, 0, 1, 0, 1, 1, 'h1D51));      // ADDS_I addr 1
        dir.push_back(mk(1, 2, 1, 2, 0, 8, 0, 1, 0, 1, 0, 0));           // ADDS_I i=8 illegal
        dir.push_back(mk(1, 16, 0, 1, 0, 4, 0, 1, 0, 1, 1, 'h6908));     // LDR addr 2
        dir.push_back(mk(1, 17, 0, 0, 0, 'h7FE, 1, 1, 0, 1, 1, 'hD1FE)); // BCOND addr 3 -> full
        dir.push_back(mk(1, 0, 0, 0, 0, 5, 0, 1, 0, 1, 1, 'h2005));      // refused while full
        dir.push_back(mk(1, 0, 0, 0, 0, 5, 0, 1, 1, 1, 1, 'h2005));      // clear
        dir.push_back(mk(1, 17, 0, 0, 0, 3, 'hF, 1, 0, 1, 0, 0));        // BCOND cond=1111
        dir.push_back(mk(1, 17, 0, 0, 0, 'h080, 2, 1, 0, 1, 0, 0));      // BCOND bad sign ext
        dir.push_back(mk(1, 19, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'hBF00));     // NOOP addr 0
        for (int k = 0; k < 3; k++)
            dir.push_back(mk(1, 1, 2, 0, 5, 0, 0, 0, 0, 1, 1, 'h462A));  // backpressure
        dir.push_back(mk(1, 1, 2, 0, 5, 0, 0, 1, 0, 1, 1, 'h462A));      // MOV addr 1
        dir.push_back(mk(1, 3, 1, 2, 3, 0, 0, 1, 0, 1, 1, 'h18D1));      // ADDS_R addr 2
        dir.push_back(mk(1, 18, 0, 0, 0, 'h400, 0, 1, 0, 1, 1, 'hE400)); // B addr 3
        dir.push_back(mk(1, 7, 0, 0, 0, 127, 0, 1, 0, 1, 1, 'hB0FF));    // refused, full
        dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));           // clear
        dir.push_back(mk(1, 4, 0, 0, 0, 128, 0, 1, 0, 1, 0, 0));         // ADD_SP 128 illegal
        dir.push_back(mk(1, 25, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));          // op 25 illegal
        dir.push_back(mk(1, 15, 7, 6, 0, 31, 0, 1, 0, 1, 1, 'h67F7));    // STR addr 0
        foreach (dir[k]) step(dir[k]);

        repeat (600) step(rand_item());

        // Async reset while a word is held by backpressure.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
        step(mk(1, 0, 1, 0, 0, 'h11, 0, 1, 0, 1, 1, 'h2111));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        #1 reset = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_instr", 32'(out_instr), 32'd0);
        check("arst_out_addr",  32'(out_addr),  32'd0);
        check("arst_err_count", 32'(err_count), 32'd0);
        model_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        step(mk(1, 13, 4, 0, 2, 0, 0, 1, 0, 1, 1, 'h4094));              // LSLS addr 0
        repeat (3) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
